// File: rtl/sprite_anim_scheduler.sv
// sprite_anim_scheduler
//   Sequences the shared 20x40 character sprite ROM for two players
//   (P0 fireboy, P1 watergirl). Each player has an animation FSM
//   (idle / run-right / run-left / jump) whose run frames alternate on a
//   video-frame timebase. Each pixel is tested against both sprite boxes,
//   overlap is arbitrated, and one ROM address plus bank/frame select is
//   emitted one vga_clk after DrawX/DrawY.
//
// Ports
//   vga_clk            pixel clock, all state on posedge
//   reset              asynchronous, active-high
//   vs                 VGA vsync (active-low), drives the frame tick
//   blank              1 = active video
//   DrawX, DrawY       current pixel
//   p0_x/p0_y, p1_x/p1_y   sprite top-left corners
//   p0_mv, p1_mv       {left,right} motion request
//   p0_air, p1_air     player airborne
//   rom_addr           sprite ROM address (ROM samples on negedge)
//   rom_bank           pixel owner: 0 = P0, 1 = P1
//   frame_sel          0 idle, 1 R1, 2 R2, 3 L1, 4 L2, 5 jump
//   hit                pixel lies inside the owner's sprite box
//
// Configuration
//   SPRITE_PRIO_RR_EN  when defined, overlap priority toggles every frame
//                      tick (reset value P1); otherwise P1 always wins.

module sprite_anim_scheduler #(
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 40,
  parameter int ADDR_W    = 10,
  parameter int FRAME_DIV = 8
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              vs,
  input  logic              blank,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        p0_x,
  input  logic [9:0]        p0_y,
  input  logic [9:0]        p1_x,
  input  logic [9:0]        p1_y,
  input  logic [1:0]        p0_mv,
  input  logic [1:0]        p1_mv,
  input  logic              p0_air,
  input  logic              p1_air,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_bank,
  output logic [2:0]        frame_sel,
  output logic              hit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_R = 2'd1,
    ST_RUN_L = 2'd2,
    ST_JUMP  = 2'd3
  } anim_state_e;

  localparam logic [7:0]        DIV_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [10:0]       SPR_W_11  = 11'(SPR_W);
  localparam logic [10:0]       SPR_H_11  = 11'(SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A   = ADDR_W'(SPR_W);

  // Per-player inputs gathered into arrays so both FSMs share one description
  logic [1:0]  mv_s  [2];
  logic        air_s [2];

  assign mv_s[0]  = p0_mv;
  assign mv_s[1]  = p1_mv;
  assign air_s[0] = p0_air;
  assign air_s[1] = p1_air;

  anim_state_e state_q [2];
  anim_state_e state_d [2];
  logic        phase_q [2];
  logic        phase_d [2];
  logic [7:0]  div_q   [2];
  logic [7:0]  div_d   [2];
  logic [2:0]  frame_s [2];

  logic vs_q;
  logic vs_d;
  logic tick_s;
  logic prio_s;

  // vsync history for falling-edge detection
  always_comb begin
    vs_d = vs;
  end

  // vsync delay flop; idles high so the first tick needs a real falling edge
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs_d;
    end
  end

  assign tick_s = vs_q & ~vs;

`ifdef SPRITE_PRIO_RR_EN
  logic prio_q;
  logic prio_d;

  // Round-robin overlap priority flips once per video frame
  always_comb begin
    if (tick_s) begin
      prio_d = ~prio_q;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register, P1 first after reset
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_s = prio_q;
`else
  assign prio_s = 1'b1;
`endif

  // Animation state, phase and divider registers for both players
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q[0] <= ST_IDLE;
      state_q[1] <= ST_IDLE;
      phase_q[0] <= 1'b0;
      phase_q[1] <= 1'b0;
      div_q[0]   <= 8'd0;
      div_q[1]   <= 8'd0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      phase_q[0] <= phase_d[0];
      phase_q[1] <= phase_d[1];
      div_q[0]   <= div_d[0];
      div_q[1]   <= div_d[1];
    end
  end

  // Next-state: airborne beats a single direction bit, which beats idle
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = ST_IDLE;
      if (air_s[p]) begin
        state_d[p] = ST_JUMP;
      end else begin
        case (mv_s[p])
          2'b01:   state_d[p] = ST_RUN_R;
          2'b10:   state_d[p] = ST_RUN_L;
          default: state_d[p] = ST_IDLE;
        endcase
      end
    end
  end

  // Run-phase divider: any state change restarts the run cycle on the same edge
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      phase_d[p] = phase_q[p];
      div_d[p]   = div_q[p];
      if (state_d[p] != state_q[p]) begin
        phase_d[p] = 1'b0;
        div_d[p]   = 8'd0;
      end else if (((state_q[p] == ST_RUN_R) || (state_q[p] == ST_RUN_L)) && tick_s) begin
        if (div_q[p] == DIV_LAST) begin
          div_d[p]   = 8'd0;
          phase_d[p] = ~phase_q[p];
        end else begin
          div_d[p]   = div_q[p] + 8'd1;
        end
      end else begin
        phase_d[p] = phase_q[p];
        div_d[p]   = div_q[p];
      end
    end
  end

  // Frame mapping uses next-state values so frame_sel matches the FSM after the edge
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      case (state_d[p])
        ST_IDLE:  frame_s[p] = 3'd0;
        ST_RUN_R: frame_s[p] = 3'd1 + {2'b00, phase_d[p]};
        ST_RUN_L: frame_s[p] = 3'd3 + {2'b00, phase_d[p]};
        ST_JUMP:  frame_s[p] = 3'd5;
        default:  frame_s[p] = 3'd0;
      endcase
    end
  end

  logic [10:0]       x11_s;
  logic [10:0]       y11_s;
  logic              in0_s;
  logic              in1_s;
  logic [9:0]        dx0_s;
  logic [9:0]        dy0_s;
  logic [9:0]        dx1_s;
  logic [9:0]        dy1_s;
  logic [ADDR_W-1:0] addr0_s;
  logic [ADDR_W-1:0] addr1_s;

  // Box test in 11 bits so px+SPR_W past the screen edge clips instead of wrapping
  always_comb begin
    x11_s   = {1'b0, DrawX};
    y11_s   = {1'b0, DrawY};
    in0_s   = blank
            & (x11_s >= {1'b0, p0_x}) & (x11_s < ({1'b0, p0_x} + SPR_W_11))
            & (y11_s >= {1'b0, p0_y}) & (y11_s < ({1'b0, p0_y} + SPR_H_11));
    in1_s   = blank
            & (x11_s >= {1'b0, p1_x}) & (x11_s < ({1'b0, p1_x} + SPR_W_11))
            & (y11_s >= {1'b0, p1_y}) & (y11_s < ({1'b0, p1_y} + SPR_H_11));
    dx0_s   = DrawX - p0_x;
    dy0_s   = DrawY - p0_y;
    dx1_s   = DrawX - p1_x;
    dy1_s   = DrawY - p1_y;
    // modular ADDR_W arithmetic equals truncating the full-width address
    addr0_s = (ADDR_W'(dy0_s) * SPR_W_A) + ADDR_W'(dx0_s);
    addr1_s = (ADDR_W'(dy1_s) * SPR_W_A) + ADDR_W'(dx1_s);
  end

  logic              owner_s;
  logic              hit_d;
  logic              rom_bank_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [2:0]        frame_sel_d;

  // Overlap arbitration and output selection; no-hit pixels report P0's frame
  always_comb begin
    case ({in1_s, in0_s})
      2'b01: begin
        owner_s = 1'b0;
        hit_d   = 1'b1;
      end
      2'b10: begin
        owner_s = 1'b1;
        hit_d   = 1'b1;
      end
      2'b11: begin
        owner_s = prio_s;
        hit_d   = 1'b1;
      end
      default: begin
        owner_s = 1'b0;
        hit_d   = 1'b0;
      end
    endcase
    if (hit_d) begin
      rom_bank_d = owner_s;
      rom_addr_d = owner_s ? addr1_s : addr0_s;
    end else begin
      rom_bank_d = 1'b0;
      rom_addr_d = '0;
    end
    frame_sel_d = owner_s ? frame_s[1] : frame_s[0];
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_bank_q;
  logic [2:0]        frame_sel_q;
  logic              hit_q;

  // Output registers, one vga_clk behind DrawX/DrawY
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr_q  <= '0;
      rom_bank_q  <= 1'b0;
      frame_sel_q <= 3'd0;
      hit_q       <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      rom_bank_q  <= rom_bank_d;
      frame_sel_q <= frame_sel_d;
      hit_q       <= hit_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_bank  = rom_bank_q;
  assign frame_sel = frame_sel_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_sprite_anim_scheduler.sv
// Testbench for sprite_anim_scheduler: a frame-level behavioural model
// (mode + tick count since entering the mode) is checked against the DUT
// every cycle, plus hand-computed literal expectations for key scenarios.

module tb_sprite_anim_scheduler;

  localparam int FD    = 8;
  localparam int SW    = 20;
  localparam int SH    = 40;
  localparam int AW    = 10;

  logic          vga_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          vs      = 1'b1;
  logic          blank   = 1'b1;
  logic [9:0]    DrawX   = 10'd0;
  logic [9:0]    DrawY   = 10'd0;
  logic [9:0]    p0_x    = 10'd100;
  logic [9:0]    p0_y    = 10'd200;
  logic [9:0]    p1_x    = 10'd500;
  logic [9:0]    p1_y    = 10'd400;
  logic [1:0]    p0_mv   = 2'b00;
  logic [1:0]    p1_mv   = 2'b00;
  logic          p0_air  = 1'b0;
  logic          p1_air  = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_bank;
  logic [2:0]    frame_sel;
  logic          hit;

  int n_checks = 0;
  int n_errors = 0;

  sprite_anim_scheduler #(
    .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW), .FRAME_DIV(FD)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .vs(vs), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
    .p0_mv(p0_mv), .p1_mv(p1_mv), .p0_air(p0_air), .p1_air(p1_air),
    .rom_addr(rom_addr), .rom_bank(rom_bank), .frame_sel(frame_sel), .hit(hit)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run right, 2 run left, 3 jump
  function automatic int mode_of(input logic [1:0] mv, input logic air);
    if (air) return 3;
    if (mv == 2'b01) return 1;
    if (mv == 2'b10) return 2;
    return 0;
  endfunction

  // run frames alternate every FD ticks spent in the same run mode
  function automatic int frame_of(input int mode, input int ticks);
    int ph;
    ph = (ticks / FD) % 2;
    if (mode == 1) return 1 + ph;
    if (mode == 2) return 3 + ph;
    if (mode == 3) return 5;
    return 0;
  endfunction

  function automatic bit in_box(input int x, input int y, input int px, input int py, input bit bl);
    return bl && (x >= px) && (x < px + SW) && (y >= py) && (y < py + SH);
  endfunction

  int m_mode  [2];
  int m_ticks [2];
  bit m_vs_prev;
  bit m_prio;
  bit exp_hit;
  bit exp_bank;
  int exp_addr;
  int exp_fs;

  always @(posedge vga_clk) begin : model_b
    int nm [2];
    int nt [2];
    bit tk, in0, in1, own;
    int a0, a1;
    if (reset) begin
      m_mode[0]  <= 0;
      m_mode[1]  <= 0;
      m_ticks[0] <= 0;
      m_ticks[1] <= 0;
      m_vs_prev  <= 1'b1;
      m_prio     <= 1'b1;
      exp_hit    <= 1'b0;
      exp_bank   <= 1'b0;
      exp_addr   <= 0;
      exp_fs     <= 0;
    end else begin
      tk    = m_vs_prev && !vs;
      nm[0] = mode_of(p0_mv, p0_air);
      nm[1] = mode_of(p1_mv, p1_air);
      for (int p = 0; p < 2; p++) begin
        if (nm[p] != m_mode[p]) nt[p] = 0;
        else if ((nm[p] == 1 || nm[p] == 2) && tk) nt[p] = m_ticks[p] + 1;
        else nt[p] = m_ticks[p];
      end
      in0 = in_box(int'(DrawX), int'(DrawY), int'(p0_x), int'(p0_y), blank);
      in1 = in_box(int'(DrawX), int'(DrawY), int'(p1_x), int'(p1_y), blank);
      own = (in0 && in1) ? m_prio : in1;
      a0  = ((int'(DrawY) - int'(p0_y)) * SW + (int'(DrawX) - int'(p0_x))) % (1 << AW);
      a1  = ((int'(DrawY) - int'(p1_y)) * SW + (int'(DrawX) - int'(p1_x))) % (1 << AW);
      exp_hit    <= in0 || in1;
      exp_bank   <= (in0 || in1) ? own : 1'b0;
      exp_addr   <= !(in0 || in1) ? 0 : (own ? a1 : a0);
      exp_fs     <= frame_of(nm[own], nt[own]);
      m_mode[0]  <= nm[0];
      m_mode[1]  <= nm[1];
      m_ticks[0] <= nt[0];
      m_ticks[1] <= nt[1];
      m_vs_prev  <= vs;
`ifdef SPRITE_PRIO_RR_EN
      if (tk) m_prio <= ~m_prio;
`endif
    end
  end

  // Every-cycle comparison against the model, 1 time unit after the edge
  always @(posedge vga_clk) begin
    #1;
    chk("model_hit",  {31'd0, hit},       {31'd0, exp_hit});
    chk("model_bank", {31'd0, rom_bank},  {31'd0, exp_bank});
    chk("model_addr", {22'd0, rom_addr},  exp_addr);
    chk("model_fsel", {29'd0, frame_sel}, exp_fs);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge vga_clk);
    #2;
  endtask

  task automatic tick_frame();
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  initial begin
    // Reset held with random pixels
    for (int i = 0; i < 5; i++) begin
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 479));
      step();
      chk("rst_hit",  {31'd0, hit}, 32'd0);
      chk("rst_addr", {22'd0, rom_addr}, 32'd0);
      chk("rst_fsel", {29'd0, frame_sel}, 32'd0);
    end

    // First pixel after release
    DrawX = 10'd105;
    DrawY = 10'd210;
    reset = 1'b0;
    step();
    chk("p0_hit",  {31'd0, hit}, 32'd1);
    chk("p0_bank", {31'd0, rom_bank}, 32'd0);
    chk("p0_addr", {22'd0, rom_addr}, 32'd205);
    chk("p0_idle", {29'd0, frame_sel}, 32'd0);

    // Run right: 8 ticks per phase
    p0_mv = 2'b01;
    step();
    chk("runr_start", {29'd0, frame_sel}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick_frame();
      if (k == 7)  chk("runr_t7",  {29'd0, frame_sel}, 32'd1);
      if (k == 8)  chk("runr_t8",  {29'd0, frame_sel}, 32'd2);
      if (k == 15) chk("runr_t15", {29'd0, frame_sel}, 32'd2);
      if (k == 16) chk("runr_t16", {29'd0, frame_sel}, 32'd1);
    end

    // Mid-count switch to run left clears the counter
    p0_mv = 2'b10;
    step();
    chk("runl_start", {29'd0, frame_sel}, 32'd3);
    for (int k = 1; k <= 8; k++) begin
      tick_frame();
      if (k == 7) chk("runl_t7", {29'd0, frame_sel}, 32'd3);
      if (k == 8) chk("runl_t8", {29'd0, frame_sel}, 32'd4);
    end

    // P1 jump overrides run request
    p0_mv = 2'b00;
    p1_x  = 10'd400;
    p1_y  = 10'd300;
    DrawX = 10'd401;
    DrawY = 10'd301;
    p1_mv = 2'b01;
    p1_air = 1'b1;
    step();
    chk("jump_fsel", {29'd0, frame_sel}, 32'd5);
    chk("jump_bank", {31'd0, rom_bank}, 32'd1);
    chk("jump_addr", {22'd0, rom_addr}, 32'd21);
    for (int k = 0; k < 3; k++) tick_frame();
    p1_air = 1'b0;
    step();
    chk("land_fsel", {29'd0, frame_sel}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick_frame();
      if (k == 7) chk("land_t7", {29'd0, frame_sel}, 32'd1);
      if (k == 8) chk("land_t8", {29'd0, frame_sel}, 32'd2);
    end

    // Full overlap at (300,100)
    p1_mv = 2'b00;
    p0_x = 10'd300; p0_y = 10'd100;
    p1_x = 10'd300; p1_y = 10'd100;
    DrawX = 10'd310; DrawY = 10'd120;
    step();
    for (int f = 0; f < 3; f++) begin
`ifndef SPRITE_PRIO_RR_EN
      chk("ovl_bank", {31'd0, rom_bank}, 32'd1);
`endif
      chk("ovl_addr", {22'd0, rom_addr}, 32'd410);
      tick_frame();
    end

    // Right screen edge: clips, never wraps
    p0_x = 10'd630; p0_y = 10'd50;
    p1_x = 10'd500; p1_y = 10'd400;
    DrawX = 10'd635; DrawY = 10'd50;
    step();
    chk("edge_hit",  {31'd0, hit}, 32'd1);
    chk("edge_addr", {22'd0, rom_addr}, 32'd5);
    DrawX = 10'd2;
    step();
    chk("wrap_hit",  {31'd0, hit}, 32'd0);
    chk("wrap_addr", {22'd0, rom_addr}, 32'd0);

    // Blanking suppresses a hit inside the box
    DrawX = 10'd635;
    blank = 1'b0;
    step();
    chk("blank_hit", {31'd0, hit}, 32'd0);
    blank = 1'b1;

    // Both directions -> idle
    p0_mv = 2'b01;
    step();
    chk("mv01_fsel", {29'd0, frame_sel}, 32'd1);
    p0_mv = 2'b11;
    step();
    chk("mv11_fsel", {29'd0, frame_sel}, 32'd0);

    // Boundary sweep over two overlapping boxes with running players and ticks
    p0_x = 10'd50; p0_y = 10'd60;
    p1_x = 10'd60; p1_y = 10'd70;
    p0_mv = 2'b01;
    p1_mv = 2'b10;
    for (int yi = 0; yi < 6; yi++) begin
      case (yi)
        0: DrawY = 10'd59;
        1: DrawY = 10'd60;
        2: DrawY = 10'd99;
        3: DrawY = 10'd100;
        4: DrawY = 10'd109;
        default: DrawY = 10'd110;
      endcase
      for (int x = 45; x <= 85; x++) begin
        DrawX = 10'(x);
        vs = ((x % 6) == 0) ? 1'b0 : 1'b1;
        step();
      end
    end
    vs = 1'b1;

    // Asynchronous reset mid-frame, then recovery
    DrawX = 10'd55; DrawY = 10'd65;
    step();
    reset = 1'b1;
    #1;
    chk("arst_hit",  {31'd0, hit}, 32'd0);
    chk("arst_addr", {22'd0, rom_addr}, 32'd0);
    chk("arst_fsel", {29'd0, frame_sel}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("rel_hit",  {31'd0, hit}, 32'd1);
    chk("rel_addr", {22'd0, rom_addr}, 32'd105);
    chk("rel_fsel", {29'd0, frame_sel}, 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
